// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit RAM between two Avalon-MM
// masters, with an optional zero-fill sweep of the RAM after reset.
module onchip_memory_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 40960,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              init_done
);

  typedef enum logic {S_CLEAR = 1'b0, S_ARB = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              last_grant_q, last_grant_d;
  logic              rd_pending_q, rd_pending_d;
  logic              rd_owner_q, rd_owner_d;
  logic              init_done_q, init_done_d;

  logic req0, req1, clearing, gnt_vld, gnt_sel, gnt_read, gnt_write;

  // gnt_sel is the port index that wins this cycle; on a tie the port that
  // did not win last time gets the slot.
  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    clearing  = (state_q == S_CLEAR);
    gnt_vld   = (state_q == S_ARB) & (req0 | req1);
    gnt_sel   = (req0 & req1) ? ~last_grant_q : req1;
    gnt_read  = gnt_sel ? m1_read : m0_read;
    gnt_write = gnt_sel ? (m1_write & ~m1_read) : (m0_write & ~m0_read);
  end

  always_comb begin
    mem_clken      = 1'b1;
    mem_chipselect = ~reset & (clearing | gnt_vld);
    mem_write      = ~reset & (clearing | (gnt_vld & gnt_write));
    if (clearing) begin
      mem_address    = clr_addr_q;
      mem_byteenable = 4'hF;
      mem_writedata  = 32'h0;
    end else begin
      mem_address    = gnt_sel ? m1_address    : m0_address;
      mem_byteenable = gnt_sel ? m1_byteenable : m0_byteenable;
      mem_writedata  = gnt_sel ? m1_writedata  : m0_writedata;
    end
    m0_waitrequest   = reset | clearing | (req0 & gnt_sel);
    m1_waitrequest   = reset | clearing | (req1 & ~gnt_sel);
    // Gating with reset drops a read response that would land in a reset cycle.
    m0_readdatavalid = ~reset & rd_pending_q & ~rd_owner_q;
    m1_readdatavalid = ~reset & rd_pending_q & rd_owner_q;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    init_done        = init_done_q;
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    last_grant_d = last_grant_q;
    rd_owner_d   = rd_owner_q;
    rd_pending_d = gnt_vld & gnt_read;
    if (clearing) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == LAST_ADDR) state_d = S_ARB;
    end
    if (gnt_vld) begin
      last_grant_d = gnt_sel;
      rd_owner_d   = gnt_sel;
    end
    init_done_d = (state_d == S_ARB);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_ARB;
      clr_addr_q   <= '0;
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      init_done_q  <= init_done_d;
    end
  end

  a_m0_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  a_m1_rw_excl: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: RAM model, directed scenarios and a
// randomized two-master run checked against a transaction-level model.
module tb_onchip_memory_arbiter;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [3:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
  logic mem_chipselect, mem_write, mem_clken, init_done;
  logic [31:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .m1_waitrequest(m1_waitrequest),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .init_done(init_done)
  );

  // Single-port RAM with one-cycle read latency (read returns pre-write data).
  logic [31:0] ram [0:255];
  bit preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hFFFF_FFFF;
    end else if (mem_chipselect && mem_clken) begin
      mem_readdata <= ram[mem_address[7:0]];
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_mem [0:255];
  bit exp_last;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; preload = 1;
    repeat (3) @(posedge clk);
    #1 preload = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = (i < DEPTH) ? 32'h0 : 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if ({init_done, mem_chipselect, mem_write} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got %b exp 000", {init_done, mem_chipselect, mem_write});
    end
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL reset_valid got %b exp 00", {m0_readdatavalid, m1_readdatavalid});
    end
  endtask

  task automatic test_clear_fill();
    step();
    reset = 0; m0_read = 1; m0_address = 16'd5;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) step();
      @(negedge clk);
      checks++;
      if ({mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
           m0_waitrequest, m1_waitrequest, init_done} !==
          {1'b1, 1'b1, 16'(i), 4'hF, 32'h0, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL clear_write[%0d] got cs=%b wr=%b a=%0d be=%h wd=%h w=%b%b init=%b exp addr %0d",
                 i, mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
                 m0_waitrequest, m1_waitrequest, init_done, i);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if ({init_done, m0_waitrequest, mem_chipselect, mem_write, mem_address} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 16'd5}) begin
      errors++;
      $display("FAIL clear_done_read got init=%b w0=%b cs=%b wr=%b a=%0d exp 1 0 1 0 5",
               init_done, m0_waitrequest, mem_chipselect, mem_write, mem_address);
    end
    step();
    m0_read = 0;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10 || m0_readdata !== exp_mem[5]) begin
      errors++;
      $display("FAIL clear_read_back got v=%b%b d=%h exp v=10 d=%h",
               m0_readdatavalid, m1_readdatavalid, m0_readdata, exp_mem[5]);
    end
    exp_last = 0;
  endtask

  task automatic test_byteenable();
    step();
    m0_write = 1; m0_address = 16'h0010; m0_writedata = 32'h0; m0_byteenable = 4'hF;
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, mem_write} !== 2'b01) begin
      errors++; $display("FAIL be_zero_accept got w=%b wr=%b exp 0 1", m0_waitrequest, mem_write);
    end
    exp_mem[16] = 32'h0;
    step();
    m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'b0011;
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, mem_byteenable, mem_writedata} !== {1'b0, 4'b0011, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL be_accept got w=%b be=%b wd=%h exp 0 0011 deadbeef",
               m0_waitrequest, mem_byteenable, mem_writedata);
    end
    exp_mem[16] = merge(exp_mem[16], 32'hDEAD_BEEF, 4'b0011);
    step();
    m0_write = 0; m0_read = 1; m0_byteenable = 4'hF;
    @(negedge clk);
    step();
    m0_read = 0;
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0000_BEEF || exp_mem[16] !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL be_readback got v=%b d=%h exp v=1 d=0000beef", m0_readdatavalid, m0_readdata);
    end
    exp_last = 0;
  endtask

  task automatic test_alternate();
    logic prev_g;
    step();
    m0_write = 1; m0_address = 16'd1; m0_writedata = 32'h1111_1111;
    @(negedge clk);
    exp_mem[1] = 32'h1111_1111;
    step();
    m0_write = 0; m1_write = 1; m1_address = 16'd2; m1_writedata = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL alt_m1_write got w=%b exp 0", m1_waitrequest);
    end
    exp_mem[2] = 32'h2222_2222;
    exp_last = 1;
    step();
    m1_write = 0; m0_read = 1; m0_address = 16'd1; m1_read = 1; m1_address = 16'd2;
    prev_g = 0;
    for (int c = 0; c < 8; c++) begin
      logic g;
      if (c > 0) step();
      @(negedge clk);
      g = !exp_last;
      checks++;
      if ({m0_waitrequest, m1_waitrequest} !== (g ? 2'b10 : 2'b01) || (c == 0 && g !== 1'b0)) begin
        errors++;
        $display("FAIL alt_grant[%0d] got w0w1=%b%b exp grant port %0d", c, m0_waitrequest, m1_waitrequest, g);
      end
      checks++;
      if (c == 0) begin
        if ({m1_readdatavalid, m0_readdatavalid} !== 2'b00) begin
          errors++; $display("FAIL alt_valid[0] got %b%b exp 00", m1_readdatavalid, m0_readdatavalid);
        end
      end else if ({m1_readdatavalid, m0_readdatavalid} !== (prev_g ? 2'b10 : 2'b01) ||
                   (prev_g ? m1_readdata : m0_readdata) !== exp_mem[prev_g ? 2 : 1]) begin
        errors++;
        $display("FAIL alt_valid[%0d] got v1v0=%b%b d0=%h d1=%h exp owner %0d data %h", c,
                 m1_readdatavalid, m0_readdatavalid, m0_readdata, m1_readdata, prev_g,
                 exp_mem[prev_g ? 2 : 1]);
      end
      exp_last = g;
      prev_g = g;
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if ({m1_readdatavalid, m0_readdatavalid} !== 2'b10 || m1_readdata !== 32'h2222_2222) begin
      errors++;
      $display("FAIL alt_drain got v1v0=%b%b d=%h exp 10 22222222", m1_readdatavalid, m0_readdatavalid, m1_readdata);
    end
  endtask

  task automatic test_rw_conflict();
    step();
    m1_write = 1; m1_address = 16'd3; m1_writedata = 32'h1234_5678;
    m0_read = 1; m0_address = 16'd3;
    @(negedge clk);
    checks++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
      errors++; $display("FAIL conflict_first got w0w1=%b%b exp 01", m0_waitrequest, m1_waitrequest);
    end
    step();
    m0_read = 0;
    @(negedge clk);
    checks++;
    if ({m1_waitrequest, mem_write, m0_readdatavalid} !== 3'b011 || m0_readdata !== exp_mem[3]) begin
      errors++;
      $display("FAIL conflict_second got w1=%b wr=%b v0=%b d=%h exp 0 1 1 %h",
               m1_waitrequest, mem_write, m0_readdatavalid, m0_readdata, exp_mem[3]);
    end
    exp_mem[3] = 32'h1234_5678;
    step();
    m1_write = 0; m0_read = 1;
    @(negedge clk);
    step();
    m0_read = 0;
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h1234_5678) begin
      errors++; $display("FAIL conflict_readback got v=%b d=%h exp 1 12345678", m0_readdatavalid, m0_readdata);
    end
    exp_last = 0;
  endtask

  task automatic test_random();
    bit act0 = 0, act1 = 0, rd0 = 0, rd1 = 0, pv = 0, pp = 0;
    logic [15:0] a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0, pd = '0;
    logic [3:0] b0 = 4'hF, b1 = 4'hF;
    for (int c = 0; c < 300; c++) begin
      logic g;
      step();
      if (!act0 && $urandom_range(0, 3) != 0) begin
        act0 = 1; rd0 = 1'($urandom_range(0, 1)); a0 = 16'(32 + $urandom_range(0, 15));
        d0 = $urandom; b0 = 4'($urandom_range(1, 15));
      end
      if (!act1 && $urandom_range(0, 3) != 0) begin
        act1 = 1; rd1 = 1'($urandom_range(0, 1)); a1 = 16'(32 + $urandom_range(0, 15));
        d1 = $urandom; b1 = 4'($urandom_range(1, 15));
      end
      m0_read = act0 & rd0; m0_write = act0 & ~rd0; m0_address = a0; m0_writedata = d0; m0_byteenable = b0;
      m1_read = act1 & rd1; m1_write = act1 & ~rd1; m1_address = a1; m1_writedata = d1; m1_byteenable = b1;
      @(negedge clk);
      g = (act0 && act1) ? !exp_last : act1;
      checks++;
      if (m0_waitrequest !== (act0 && g) || m1_waitrequest !== (act1 && !g)) begin
        errors++;
        $display("FAIL rand_grant[%0d] got w0w1=%b%b exp winner %0d req %b%b", c,
                 m0_waitrequest, m1_waitrequest, g, act0, act1);
      end
      checks++;
      if ({m1_readdatavalid, m0_readdatavalid} !== {pv && pp, pv && !pp} ||
          (pv && (pp ? m1_readdata : m0_readdata) !== pd)) begin
        errors++;
        $display("FAIL rand_read[%0d] got v1v0=%b%b d0=%h d1=%h exp valid %b owner %0d data %h", c,
                 m1_readdatavalid, m0_readdatavalid, m0_readdata, m1_readdata, pv, pp, pd);
      end
      pv = 0;
      if (act0 || act1) begin
        exp_last = g;
        if (g) begin
          if (rd1) begin pv = 1; pp = 1; pd = exp_mem[a1[7:0]]; end
          else exp_mem[a1[7:0]] = merge(exp_mem[a1[7:0]], d1, b1);
          act1 = 0;
        end else begin
          if (rd0) begin pv = 1; pp = 0; pd = exp_mem[a0[7:0]]; end
          else exp_mem[a0[7:0]] = merge(exp_mem[a0[7:0]], d0, b0);
          act0 = 0;
        end
      end
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if ({m1_readdatavalid, m0_readdatavalid} !== {pv && pp, pv && !pp} ||
        (pv && (pp ? m1_readdata : m0_readdata) !== pd)) begin
      errors++;
      $display("FAIL rand_drain got v1v0=%b%b exp valid %b owner %0d data %h",
               m1_readdatavalid, m0_readdatavalid, pv, pp, pd);
    end
  endtask

  task automatic test_reset_mid_clear();
    step();
    idle(); reset = 1;
    @(negedge clk);
    step();
    reset = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      @(negedge clk);
    end
    checks++;
    if (mem_address !== 16'd8 || init_done !== 1'b0) begin
      errors++; $display("FAIL midclr_progress got a=%0d init=%b exp 8 0", mem_address, init_done);
    end
    step();
    reset = 1;
    @(negedge clk);
    checks++;
    if ({mem_chipselect, mem_write, init_done} !== 3'b000) begin
      errors++; $display("FAIL midclr_reset got cs=%b wr=%b init=%b exp 000", mem_chipselect, mem_write, init_done);
    end
    step();
    reset = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) step();
      @(negedge clk);
      checks++;
      if ({mem_chipselect, mem_write, mem_address, init_done} !== {1'b1, 1'b1, 16'(i), 1'b0}) begin
        errors++;
        $display("FAIL midclr_restart[%0d] got cs=%b wr=%b a=%0d init=%b exp addr %0d init 0",
                 i, mem_chipselect, mem_write, mem_address, init_done, i);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1) begin
      errors++; $display("FAIL midclr_done got init=%b exp 1", init_done);
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    exp_last = 1;
  endtask

  task automatic test_reset_pending_read();
    step();
    m1_read = 1; m1_address = 16'd2;
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0) begin
      errors++; $display("FAIL pend_grant got w1=%b exp 0", m1_waitrequest);
    end
    step();
    m1_read = 0; reset = 1;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL pend_suppress got v0v1=%b%b exp 00", m0_readdatavalid, m1_readdatavalid);
    end
    step();
    reset = 0;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      errors++; $display("FAIL pend_after_reset got v0v1=%b%b exp 00", m0_readdatavalid, m1_readdatavalid);
    end
    repeat (DEPTH - 1) step();
    step();
    m0_read = 1; m0_address = 16'd4; m1_read = 1; m1_address = 16'd5;
    @(negedge clk);
    checks++;
    if ({init_done, m0_waitrequest, m1_waitrequest, mem_address} !== {1'b1, 1'b0, 1'b1, 16'd4}) begin
      errors++;
      $display("FAIL pend_tie got init=%b w0w1=%b%b a=%0d exp 1 01 4",
               init_done, m0_waitrequest, m1_waitrequest, mem_address);
    end
    step();
    m0_read = 0;
    @(negedge clk);
    checks++;
    if ({m0_readdatavalid, m1_waitrequest} !== 2'b10 || m0_readdata !== exp_mem[4]) begin
      errors++;
      $display("FAIL pend_tie_next got v0=%b w1=%b d=%h exp 1 0 %h",
               m0_readdatavalid, m1_waitrequest, m0_readdata, exp_mem[4]);
    end
    step();
    idle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_fill();
    test_byteenable();
    test_alternate();
    test_rw_conflict();
    test_random();
    test_reset_mid_clear();
    test_reset_pending_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
